// File: rtl/iq_mag_detector.sv
// Multi-channel I/Q correlating magnitude detector: per-channel quadrature NCOs
// integrate a 1-bit stream per window, then drain one magnitude per channel.
module iq_mag_detector #(
    parameter  int unsigned N_CH    = 4,
    parameter  int unsigned PHASE_W = 16,
    parameter  int unsigned ACC_W   = 10,
    parameter  int unsigned WIN_LEN = 1024,
    localparam int unsigned CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      sig,
    input  logic [N_CH*PHASE_W-1:0]   freq_word,
    input  logic                      mode,
    output logic [ACC_W-1:0]          mag,
    output logic [CH_W-1:0]           mag_ch,
    output logic                      mag_valid,
    input  logic                      mag_ready,
    output logic                      overrun
);

    localparam int unsigned CNT_W = $clog2(WIN_LEN);
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-2){1'b0}}, 1'b1};
    localparam logic signed [ACC_W-1:0] ACC_ONE = {{(ACC_W-1){1'b0}}, 1'b1};
    localparam logic [PHASE_W-1:0]      QUARTER = {2'b01, {(PHASE_W-2){1'b0}}};
    localparam logic [CH_W-1:0]         CH_LAST = CH_W'(N_CH - 1);
    localparam logic [CNT_W-1:0]        CNT_END = CNT_W'(WIN_LEN - 1);

    typedef enum logic [1:0] {IDLE, ABS, COMB, OUT} state_t;

    state_t state, state_n;

    logic [PHASE_W-1:0]      phase  [N_CH];
    logic signed [ACC_W-1:0] acc_i  [N_CH];
    logic signed [ACC_W-1:0] acc_q  [N_CH];
    logic signed [ACC_W-1:0] nxt_i  [N_CH];
    logic signed [ACC_W-1:0] nxt_q  [N_CH];
    logic signed [ACC_W-1:0] snap_i [N_CH];
    logic signed [ACC_W-1:0] snap_q [N_CH];
    logic [CNT_W-1:0]        win_cnt;
    logic                    mode_l;
    logic [CH_W-1:0]         ch;
    logic [ACC_W-2:0]        a_mag, b_mag, hi_c, lo_c;
    logic [ACC_W-1:0]        comb_mag_c;
    logic                    win_end_c, capture_c;

    // Saturating +/-1 step, symmetric around zero.
    function automatic logic signed [ACC_W-1:0] acc_step(input logic signed [ACC_W-1:0] acc,
                                                         input logic hit);
        if (hit) return (acc == ACC_MAX) ? acc : acc + ACC_ONE;
        return (acc == ACC_MIN) ? acc : acc - ACC_ONE;
    endfunction

    function automatic logic [ACC_W-2:0] abs_mag(input logic signed [ACC_W-1:0] x);
        logic signed [ACC_W-1:0] t;
        t = x[ACC_W-1] ? -x : x;
        return t[ACC_W-2:0];
    endfunction

    assign win_end_c = en && (win_cnt == CNT_END);
    assign capture_c = win_end_c && (state == IDLE);

    // Quadrature codes from the current phase and the next accumulator values.
    always_comb begin
        logic [PHASE_W-1:0] q_ph;
        q_ph = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            q_ph     = phase[k] + QUARTER;
            nxt_i[k] = acc_step(acc_i[k], sig == phase[k][PHASE_W-1]);
            nxt_q[k] = acc_step(acc_q[k], sig == q_ph[PHASE_W-1]);
        end
    end

    // Front end: NCOs, correlators and window counter, all gated by en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt <= '0;
            for (int unsigned k = 0; k < N_CH; k++) begin
                phase[k] <= '0;
                acc_i[k] <= '0;
                acc_q[k] <= '0;
            end
        end else if (en) begin
            win_cnt <= win_end_c ? '0 : win_cnt + CNT_W'(1);
            for (int unsigned k = 0; k < N_CH; k++) begin
                phase[k] <= phase[k] + freq_word[k*PHASE_W +: PHASE_W];
                acc_i[k] <= win_end_c ? '0 : nxt_i[k];
                acc_q[k] <= win_end_c ? '0 : nxt_q[k];
            end
        end
    end

    // Snapshot bank; a window end while draining is dropped and flagged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_l  <= 1'b0;
            overrun <= 1'b0;
            for (int unsigned k = 0; k < N_CH; k++) begin
                snap_i[k] <= '0;
                snap_q[k] <= '0;
            end
        end else begin
            if (capture_c) begin
                mode_l <= mode;
                for (int unsigned k = 0; k < N_CH; k++) begin
                    snap_i[k] <= nxt_i[k];
                    snap_q[k] <= nxt_q[k];
                end
            end
            if (win_end_c && (state != IDLE)) overrun <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (capture_c) state_n = ABS;
            ABS:     state_n = COMB;
            COMB:    state_n = OUT;
            OUT:     if (mag_ready) state_n = (ch == CH_LAST) ? IDLE : ABS;
            default: state_n = IDLE;
        endcase
    end

    // Magnitude combiner: |I|+|Q| or max + min/2.
    always_comb begin
        hi_c       = (a_mag >= b_mag) ? a_mag : b_mag;
        lo_c       = (a_mag >= b_mag) ? b_mag : a_mag;
        comb_mag_c = mode_l ? ({1'b0, hi_c} + ACC_W'(lo_c >> 1))
                            : ({1'b0, a_mag} + {1'b0, b_mag});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch        <= '0;
            a_mag     <= '0;
            b_mag     <= '0;
            mag       <= '0;
            mag_ch    <= '0;
            mag_valid <= 1'b0;
        end else begin
            mag_valid <= (state_n == OUT);
            case (state)
                IDLE: if (capture_c) ch <= '0;
                ABS: begin
                    a_mag <= abs_mag(snap_i[ch]);
                    b_mag <= abs_mag(snap_q[ch]);
                end
                COMB: begin
                    mag    <= comb_mag_c;
                    mag_ch <= ch;
                end
                OUT: if (mag_ready && (ch != CH_LAST)) ch <= ch + CH_W'(1);
                default: ;
            endcase
        end
    end

endmodule
